mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage: accepts one instruction per slot from EX/MEM and performs the data-memory access for loads and stores.
- Loads and stores use a valid/ready request plus response handshake.
- Formats load data: byte/half extraction and sign/zero extension.
- Drives the registered MEM/WB signals (rd_data, rd_addr, dm_out, reg_wr, dm2reg) consumed by WB.
- Asserts mem_stall back to the hazard unit while an access is outstanding.

Parameters:
- DATA_W, 32, datapath and memory word width (matches `DATA_BITS).
- REG_W, 5, register index width (matches `REG_BITS).
- ADDR_W, 32, data-memory byte address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a live instruction
- ex_alu_result  in  DATA_W  ALU result / effective address
- ex_rs2_data  in  DATA_W  store data
- ex_rd_addr  in  REG_W  destination register
- ex_reg_wr  in  1  instruction writes rd
- ex_dm_rd  in  1  load
- ex_dm_wr  in  1  store (never both with ex_dm_rd)
- ex_funct3  in  3  access size/sign
- dm_req  out  1  memory request valid
- dm_ready  in  1  memory accepts request
- dm_we  out  4  byte write strobe (0 = read)
- dm_addr  out  ADDR_W  word-aligned address
- dm_wdata  out  DATA_W  lane-replicated store data
- dm_rvalid  in  1  read response valid
- dm_rdata  in  DATA_W  read response word
- mem_stall  out  1  hold EX/MEM and earlier stages
- wb_rd_data  out  DATA_W  registered ALU result
- wb_rd_addr  out  REG_W  registered rd
- wb_dm_out  out  DATA_W  registered formatted load data
- wb_reg_wr  out  1  registered write enable
- wb_dm2reg  out  1  WB selects wb_dm_out

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. All wb_* outputs to 0. dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0. mem_stall=0.
- FSM states: IDLE, REQ, RESP.
  - IDLE + ex_valid + (ex_dm_rd|ex_dm_wr): dm_req asserted combinationally this cycle.
    - Accepted (dm_ready=1): store completes; load goes to RESP.
    - Not accepted: go to REQ.
  - REQ: dm_req held, with address/data/strobe stable, until dm_ready. Then store returns to IDLE; load goes to RESP.
  - RESP: wait for dm_rvalid, then the load completes and the FSM returns to IDLE.
- dm_rvalid outside RESP is ignored, including a stray response after reset. A response is never taken in the accept cycle.
- mem_stall = memory op present and not completing this cycle. It is combinational and deasserts in the completion cycle.
- MEM/WB register updates every cycle:
  - Completion cycle, or a non-memory ex_valid: capture rd_data=ex_alu_result, rd_addr, reg_wr=ex_reg_wr&ex_valid, dm2reg=ex_dm_rd, and dm_out = formatted data (loads).
  - mem_stall=1: bubble (wb_reg_wr=0, wb_dm2reg=0, other wb_* hold).
  - ex_valid=0: bubble.
- Latency:
  - Non-memory instruction: 1 cycle to WB.
  - Store: 1 cycle with ready.
  - Load: minimum 2 cycles.
- dm_addr = {addr[ADDR_W-1:2], 2'b00}, with offset = addr[1:0].
- Stores:
  - SB: strobe 4'b0001<<offset, byte replicated ×4.
  - SH: strobe 4'b0011<<offset, half replicated ×2.
  - SW: strobe 4'b1111.
- Loads, selected lane shifted down by offset×8:
  - LB: sign-extended.
  - LBU: zero-extended.
  - LH / LHU: halfword, sign- / zero-extended.
  - LW: full word.
  - Undefined funct3: treated as LW/SW.
- Misaligned: halfword with offset[0]=1, or word with offset≠0. Handling depends on the optional feature.
- Reset mid-access: the FSM is abandoned with no completion and no WB write.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access raises no dm_req and completes in 1 cycle with wb_reg_wr=0.
  - Adds port misalign_err (out, 1): registered 1-cycle pulse in the following cycle.
  - Adds port misalign_addr (out, ADDR_W): holds the faulting address until the next fault. Resets to 0.
- Undefined: no extra ports. The offset is forced to the natural alignment (half: offset[0]=0, word: offset=0) and the access proceeds normally.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE, REQ, RESP) and funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101).
- Package functions: store_strobe(), store_replicate().
- One combinational sub-module mem_load_align(funct3, offset, rdata → dm_out). Unit-testable separately.

Test Plan:
- ALU op rd=5, result 0x1234, no mem op → next cycle wb_rd_data=0x1234, wb_rd_addr=5, wb_reg_wr=1, wb_dm2reg=0, mem_stall never 1.
- SB addr 0x103, rs2=0xAB, dm_ready=1 immediately → dm_addr=0x100, dm_we=4'b1000, dm_wdata=0xABABABAB, no stall, wb_reg_wr=0.
- LB addr 0x102, ready held low 3 cycles, rdata=0x00800000 two cycles after accept → mem_stall high throughout, bubbles into WB, then wb_dm_out=0xFFFFFF80, wb_dm2reg=1.
- LHU addr 0x102, rdata=0xBEEF1234 → wb_dm_out=0x0000BEEF. LW addr 0x200, rdata=0xCAFEF00D → 0xCAFEF00D.
- rst_n pulled low in RESP, stray dm_rvalid after release → all wb_* = 0, FSM IDLE, response ignored, next ALU op flows normally.
- Misaligned LW addr 0x101:
  - with MEM_MISALIGN_TRAP_EN: no dm_req, misaligned_err pulse, misalign_addr=0x101.
  - without: dm_addr=0x100, full-word load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// MEM stage shared types, funct3 codes and store helpers.
// Imported by mem_access_stage and mem_load_align.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_byte(
    input logic [2:0] f3
  );
    return f3[1:0] == F3_B[1:0];
  endfunction

  function automatic logic is_half(
    input logic [2:0] f3
  );
    return f3[1:0] == F3_H[1:0];
  endfunction

  function automatic logic is_uns(
    input logic [2:0] f3
  );
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    if (is_byte(f3))
      r = 1'b0;
    else if (is_half(f3))
      r = off[0];
    else
      r = (off != 2'b00) || (f3 == F3_W && off != 2'b00);
    return r;
  endfunction

  function automatic logic [1:0] natural_offset(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [1:0] r;
    if (is_byte(f3))
      r = off;
    else if (is_half(f3))
      r = {off[1], 1'b0};
    else
      r = 2'b00;
    return r;
  endfunction

  function automatic logic [3:0] store_strobe(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] r;
    if (is_byte(f3))
      r = 4'b0001 << off;
    else if (is_half(f3))
      r = 4'b0011 << off;
    else
      r = 4'b1111;
    return r;
  endfunction

  function automatic logic [31:0] store_replicate(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] r;
    if (is_byte(f3))
      r = {4{d[7:0]}};
    else if (is_half(f3))
      r = {2{d[15:0]}};
    else
      r = d;
    return r;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: lane select, shift down, sign/zero extend.
// Purely combinational.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dm_out
);

  logic [DATA_W-1:0] sh;
  logic              uns;

  assign sh  = rdata >> {offset, 3'b000};
  assign uns = is_uns(funct3);

  // Pick the access width and extend the low lane.
  always_comb begin
    dm_out = sh;
    unique case (1'b1)
      is_byte(funct3):
        dm_out = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                     : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      is_half(funct3):
        dm_out = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                     : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default:
        dm_out = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory handshake, load formatting, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of aligning.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rs2_data,
  input  logic [REG_W-1:0]  ex_rd_addr,
  input  logic              ex_reg_wr,
  input  logic              ex_dm_rd,
  input  logic              ex_dm_wr,
  input  logic [2:0]        ex_funct3,
  output logic              dm_req,
  input  logic              dm_ready,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
  output logic [ADDR_W-1:0] misalign_addr,
`endif
  output logic [DATA_W-1:0] wb_rd_data,
  output logic [REG_W-1:0]  wb_rd_addr,
  output logic [DATA_W-1:0] wb_dm_out,
  output logic              wb_reg_wr,
  output logic              wb_dm2reg
);

  mem_state_e state;

  logic              mem_op;
  logic              trap;
  logic              idle_go;
  logic              done;
  logic              busy;
  logic              nonmem;
  logic [1:0]        off_raw;
  logic [1:0]        off_ex;
  logic [ADDR_W-1:0] addr_ex;
  logic [3:0]        we_ex;
  logic [DATA_W-1:0] wdata_ex;
  logic [DATA_W-1:0] ld_data;

  logic [ADDR_W-1:0] q_addr;
  logic [3:0]        q_we;
  logic [DATA_W-1:0] q_wdata;
  logic [2:0]        q_f3;
  logic [1:0]        q_off;
  logic              q_load;
  logic [REG_W-1:0]  q_rd;
  logic              q_reg_wr;
  logic [DATA_W-1:0] q_alu;

  assign mem_op  = ex_valid & (ex_dm_rd | ex_dm_wr);
  assign off_raw = ex_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign off_ex = off_raw;
  assign trap   = (state == IDLE) & mem_op
                & misaligned(ex_funct3, off_raw);
`else
  assign off_ex = natural_offset(ex_funct3, off_raw);
  assign trap   = 1'b0;
`endif

  assign addr_ex  = {ex_alu_result[ADDR_W-1:2], 2'b00};
  assign we_ex    = ex_dm_wr ? store_strobe(ex_funct3, off_ex)
                             : 4'b0000;
  assign wdata_ex = ex_dm_wr
                  ? store_replicate(ex_funct3, ex_rs2_data)
                  : '0;

  assign idle_go = (state == IDLE) & mem_op & ~trap;
  assign dm_req  = idle_go | (state == REQ);

  // Request fields come from EX when idle, from the latch while waiting.
  always_comb begin
    dm_addr  = '0;
    dm_we    = 4'b0000;
    dm_wdata = '0;
    if (state == REQ) begin
      dm_addr  = q_addr;
      dm_we    = q_we;
      dm_wdata = q_wdata;
    end else if (idle_go) begin
      dm_addr  = addr_ex;
      dm_we    = we_ex;
      dm_wdata = wdata_ex;
    end
  end

  // Completion: store on accept, load on response, trap at once.
  always_comb begin
    done = 1'b0;
    case (state)
      IDLE:    done = trap | (idle_go & dm_ready & ex_dm_wr);
      REQ:     done = dm_ready & ~q_load;
      RESP:    done = dm_rvalid;
      default: done = 1'b0;
    endcase
  end

  assign busy      = (state != IDLE) | mem_op;
  assign mem_stall = busy & ~done;
  assign nonmem    = (state == IDLE) & ex_valid
                   & ~(ex_dm_rd | ex_dm_wr);

  mem_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .funct3 (q_f3),
    .offset (q_off),
    .rdata  (dm_rdata),
    .dm_out (ld_data)
  );

  // Access FSM plus the held request it issues and completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      q_addr   <= '0;
      q_we     <= 4'b0000;
      q_wdata  <= '0;
      q_f3     <= 3'b000;
      q_off    <= 2'b00;
      q_load   <= 1'b0;
      q_rd     <= '0;
      q_reg_wr <= 1'b0;
      q_alu    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_go) begin
            q_addr   <= addr_ex;
            q_we     <= we_ex;
            q_wdata  <= wdata_ex;
            q_f3     <= ex_funct3;
            q_off    <= off_ex;
            q_load   <= ex_dm_rd;
            q_rd     <= ex_rd_addr;
            q_reg_wr <= ex_reg_wr;
            q_alu    <= ex_alu_result;
            if (dm_ready)
              state <= ex_dm_rd ? RESP : IDLE;
            else
              state <= REQ;
          end
        end
        REQ: begin
          if (dm_ready)
            state <= q_load ? RESP : IDLE;
        end
        RESP: begin
          if (dm_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: capture on completion, bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_data <= '0;
      wb_rd_addr <= '0;
      wb_dm_out  <= '0;
      wb_reg_wr  <= 1'b0;
      wb_dm2reg  <= 1'b0;
    end else if (trap) begin
      wb_rd_data <= ex_alu_result;
      wb_rd_addr <= ex_rd_addr;
      wb_reg_wr  <= 1'b0;
      wb_dm2reg  <= 1'b0;
    end else if (done | nonmem) begin
      if (state == IDLE) begin
        wb_rd_data <= ex_alu_result;
        wb_rd_addr <= ex_rd_addr;
        wb_reg_wr  <= ex_reg_wr & ex_valid;
        wb_dm2reg  <= ex_dm_rd;
      end else begin
        wb_rd_data <= q_alu;
        wb_rd_addr <= q_rd;
        wb_reg_wr  <= q_reg_wr;
        wb_dm2reg  <= q_load;
        if (q_load)
          wb_dm_out <= ld_data;
      end
    end else begin
      wb_reg_wr <= 1'b0;
      wb_dm2reg <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Fault pulse and sticky faulting address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= trap;
      if (trap)
        misalign_addr <= ex_alu_result[ADDR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table plus
// hand-written stall, reset and misalignment sequences.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr;
  logic        ex_dm_rd;
  logic        ex_dm_wr;
  logic [2:0]  ex_funct3;
  logic        dm_req;
  logic        dm_ready;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_stall;
  logic [31:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_dm_out;
  logic        wb_reg_wr;
  logic        wb_dm2reg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_wr     (ex_reg_wr),
    .ex_dm_rd      (ex_dm_rd),
    .ex_dm_wr      (ex_dm_wr),
    .ex_funct3     (ex_funct3),
    .dm_req        (dm_req),
    .dm_ready      (dm_ready),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rvalid     (dm_rvalid),
    .dm_rdata      (dm_rdata),
    .mem_stall     (mem_stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr),
`endif
    .wb_rd_data    (wb_rd_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_dm_out     (wb_dm_out),
    .wb_reg_wr     (wb_reg_wr),
    .wb_dm2reg     (wb_dm2reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_out;
    logic        e_rw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] rs2,
    input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
    input logic [31:0] e_addr, input logic [3:0] e_we,
    input logic [31:0] e_wdata, input logic [31:0] e_out,
    input logic e_rw);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
    v.rs2 = rs2; v.rd = rd; v.rw = rw; v.rdata = rdata;
    v.e_addr = e_addr; v.e_we = e_we; v.e_wdata = e_wdata;
    v.e_out = e_out; v.e_rw = e_rw;
    return v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_dm_rd = 0; ex_dm_wr = 0; ex_reg_wr = 0;
    dm_ready = 0; dm_rvalid = 0;
  endtask

  task automatic drive(input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd,
                       input logic rw);
    ex_valid = 1; ex_dm_rd = ld; ex_dm_wr = st; ex_funct3 = f3;
    ex_alu_result = a; ex_rs2_data = d; ex_rd_addr = rd;
    ex_reg_wr = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    drive(v.ld, v.st, v.f3, v.addr, v.rs2, v.rd, v.rw);
    dm_ready = 1; dm_rvalid = 0;
    #3;
    chk({p, " dm_req"}, {31'd0, dm_req}, {31'd0, v.ld | v.st});
    chk({p, " stall"}, {31'd0, mem_stall}, {31'd0, v.ld});
    if (v.ld | v.st) begin
      chk({p, " dm_addr"}, dm_addr, v.e_addr);
      chk({p, " dm_we"}, {28'd0, dm_we}, {28'd0, v.e_we});
    end
    if (v.st)
      chk({p, " dm_wdata"}, dm_wdata, v.e_wdata);
    step();
    if (v.ld) begin
      dm_ready = 0; dm_rvalid = 1; dm_rdata = v.rdata;
      #3;
      chk({p, " resp stall"}, {31'd0, mem_stall}, 32'd0);
      step();
    end
    idle_inputs();
    chk({p, " wb_rd_data"}, wb_rd_data, v.addr);
    chk({p, " wb_rd_addr"}, {27'd0, wb_rd_addr}, {27'd0, v.rd});
    chk({p, " wb_reg_wr"}, {31'd0, wb_reg_wr}, {31'd0, v.e_rw});
    chk({p, " wb_dm2reg"}, {31'd0, wb_dm2reg}, {31'd0, v.ld});
    if (v.ld)
      chk({p, " wb_dm_out"}, wb_dm_out, v.e_out);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 3'b000, 32'h1234, 0, 5, 1, 0,
                  0, 4'b0000, 0, 0, 1);
    vecs[1]  = mk(0, 1, 3'b000, 32'h103, 32'hAB, 0, 0, 0,
                  32'h100, 4'b1000, 32'hABABABAB, 0, 0);
    vecs[2]  = mk(0, 1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0,
                  32'h100, 4'b1100, 32'hBEEFBEEF, 0, 0);
    vecs[3]  = mk(0, 1, 3'b010, 32'h204, 32'hDEADBEEF, 0, 0, 0,
                  32'h204, 4'b1111, 32'hDEADBEEF, 0, 0);
    vecs[4]  = mk(1, 0, 3'b101, 32'h102, 0, 7, 1, 32'hBEEF1234,
                  32'h100, 4'b0000, 0, 32'h0000BEEF, 1);
    vecs[5]  = mk(1, 0, 3'b010, 32'h200, 0, 8, 1, 32'hCAFEF00D,
                  32'h200, 4'b0000, 0, 32'hCAFEF00D, 1);
    vecs[6]  = mk(1, 0, 3'b001, 32'h100, 0, 9, 1, 32'h12348001,
                  32'h100, 4'b0000, 0, 32'hFFFF8001, 1);
    vecs[7]  = mk(1, 0, 3'b100, 32'h101, 0, 10, 1, 32'h00009A00,
                  32'h100, 4'b0000, 0, 32'h0000009A, 1);
    vecs[8]  = mk(1, 0, 3'b000, 32'h103, 0, 11, 1, 32'h7F000000,
                  32'h100, 4'b0000, 0, 32'h0000007F, 1);
    vecs[9]  = mk(1, 0, 3'b011, 32'h300, 0, 12, 1, 32'h11223344,
                  32'h300, 4'b0000, 0, 32'h11223344, 1);
    vecs[10] = mk(0, 1, 3'b111, 32'h304, 32'h0BADF00D, 0, 0, 0,
                  32'h304, 4'b1111, 32'h0BADF00D, 0, 0);
    vecs[11] = mk(1, 0, 3'b000, 32'h101, 0, 13, 1, 32'h0000F100,
                  32'h100, 4'b0000, 0, 32'hFFFFFFF1, 1);

    rst_n = 0;
    idle_inputs();
    ex_funct3 = 0; ex_alu_result = 0; ex_rs2_data = 0;
    ex_rd_addr = 0; dm_rdata = 0;
    #12;
    chk("rst wb_rd_data", wb_rd_data, 0);
    chk("rst wb_rd_addr", {27'd0, wb_rd_addr}, 0);
    chk("rst wb_dm_out", wb_dm_out, 0);
    chk("rst wb_reg_wr", {31'd0, wb_reg_wr}, 0);
    chk("rst wb_dm2reg", {31'd0, wb_dm2reg}, 0);
    chk("rst dm_req", {31'd0, dm_req}, 0);
    chk("rst dm_we", {28'd0, dm_we}, 0);
    chk("rst dm_addr", dm_addr, 0);
    chk("rst dm_wdata", dm_wdata, 0);
    chk("rst stall", {31'd0, mem_stall}, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 12; i++)
      run_vec(i, vecs[i]);

    // LB with ready withheld for 3 cycles, response 2 cycles after accept
    drive(1, 0, 3'b000, 32'h102, 0, 14, 1);
    dm_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("wait dm_req", {31'd0, dm_req}, 1);
      chk("wait stall", {31'd0, mem_stall}, 1);
      chk("wait dm_addr", dm_addr, 32'h100);
      step();
      chk("wait bubble", {31'd0, wb_reg_wr}, 0);
    end
    dm_ready = 1;
    #3;
    chk("accept stall", {31'd0, mem_stall}, 1);
    step();
    dm_ready = 0;
    chk("resp dm_req", {31'd0, dm_req}, 0);
    chk("resp stall", {31'd0, mem_stall}, 1);
    step();
    chk("resp bubble", {31'd0, wb_reg_wr}, 0);
    dm_rvalid = 1; dm_rdata = 32'h00800000;
    #3;
    chk("lb done stall", {31'd0, mem_stall}, 0);
    step();
    idle_inputs();
    chk("lb wb_dm_out", wb_dm_out, 32'hFFFFFF80);
    chk("lb wb_dm2reg", {31'd0, wb_dm2reg}, 1);
    chk("lb wb_reg_wr", {31'd0, wb_reg_wr}, 1);
    chk("lb wb_rd_addr", {27'd0, wb_rd_addr}, 14);

    // Reset while in RESP, stray response afterwards
    drive(1, 0, 3'b010, 32'h200, 0, 15, 1);
    dm_ready = 1;
    step();
    idle_inputs();
    rst_n = 0;
    #2;
    chk("mid rst wb_rd_data", wb_rd_data, 0);
    chk("mid rst wb_rd_addr", {27'd0, wb_rd_addr}, 0);
    chk("mid rst wb_dm_out", wb_dm_out, 0);
    chk("mid rst wb_dm2reg", {31'd0, wb_dm2reg}, 0);
    chk("mid rst dm_req", {31'd0, dm_req}, 0);
    #2;
    rst_n = 1;
    step();
    dm_rvalid = 1; dm_rdata = 32'hDEAD0000;
    #3;
    chk("stray stall", {31'd0, mem_stall}, 0);
    step();
    dm_rvalid = 0;
    chk("stray wb_reg_wr", {31'd0, wb_reg_wr}, 0);
    chk("stray wb_dm2reg", {31'd0, wb_dm2reg}, 0);
    chk("stray wb_dm_out", wb_dm_out, 0);
    drive(0, 0, 3'b000, 32'h55, 0, 9, 1);
    step();
    idle_inputs();
    chk("post rst wb_rd_data", wb_rd_data, 32'h55);
    chk("post rst wb_rd_addr", {27'd0, wb_rd_addr}, 9);
    chk("post rst wb_reg_wr", {31'd0, wb_reg_wr}, 1);

    // Misaligned word load at 0x101
    drive(1, 0, 3'b010, 32'h101, 0, 3, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    dm_ready = 1;
    #3;
    chk("mis dm_req", {31'd0, dm_req}, 0);
    chk("mis stall", {31'd0, mem_stall}, 0);
    step();
    idle_inputs();
    chk("mis wb_reg_wr", {31'd0, wb_reg_wr}, 0);
    chk("mis err", {31'd0, misalign_err}, 1);
    chk("mis addr", misalign_addr, 32'h101);
    step();
    chk("mis err pulse", {31'd0, misalign_err}, 0);
    chk("mis addr hold", misalign_addr, 32'h101);
`else
    dm_ready = 1;
    #3;
    chk("mis dm_req", {31'd0, dm_req}, 1);
    chk("mis dm_addr", dm_addr, 32'h100);
    chk("mis dm_we", {28'd0, dm_we}, 0);
    step();
    dm_ready = 0; dm_rvalid = 1; dm_rdata = 32'hA1B2C3D4;
    step();
    idle_inputs();
    chk("mis wb_dm_out", wb_dm_out, 32'hA1B2C3D4);
    chk("mis wb_reg_wr", {31'd0, wb_reg_wr}, 1);
    drive(0, 1, 3'b001, 32'h103, 32'h5678, 0, 0);
    dm_ready = 1;
    #3;
    chk("mis sh dm_we", {28'd0, dm_we}, {28'd0, 4'b1100});
    chk("mis sh dm_wdata", dm_wdata, 32'h56785678);
    step();
    idle_inputs();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
